// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO registers for the E stage.
// Multi-cycle ops compute the result at issue, hold it in shadow registers and commit when the countdown expires.
`timescale 1ns/1ps
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [31:0]   hi_n;
  logic [31:0]   lo_n;
  logic          commit_n;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        is_sdiv;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_commit;

  assign prod_u = {32'b0, rs_val} * {32'b0, rt_val};
  assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});

  // One unsigned divider serves both div and divu; signed div works on magnitudes.
  assign is_sdiv = (md_op == 3'd2);
  assign dvd = (is_sdiv && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
  assign dvs = (rt_val == 32'd0) ? 32'd1 :
               ((is_sdiv && rt_val[31]) ? (32'd0 - rt_val) : rt_val);
  assign uq = dvd / dvs;
  assign ur = dvd % dvs;

  always_comb begin
    res_hi     = 32'd0;
    res_lo     = 32'd0;
    res_commit = 1'b1;
    case (md_op)
      3'd0: {res_hi, res_lo} = prod_s;
      3'd1: {res_hi, res_lo} = prod_u;
      3'd2: begin
        res_commit = (rt_val != 32'd0);
        if (rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF) begin
          res_lo = 32'h8000_0000;
          res_hi = 32'd0;
        end else begin
          res_lo = (rs_val[31] ^ rt_val[31]) ? (32'd0 - uq) : uq;
          res_hi = rs_val[31] ? (32'd0 - ur) : ur;
        end
      end
      3'd3: begin
        res_commit = (rt_val != 32'd0);
        res_lo     = uq;
        res_hi     = ur;
      end
      default: res_commit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      busy     <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      hi_n     <= 32'd0;
      lo_n     <= 32'd0;
      commit_n <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (!md_op[2]) begin
              hi_n     <= res_hi;
              lo_n     <= res_lo;
              commit_n <= res_commit;
              count    <= md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              state    <= RUN;
              busy     <= 1'b1;
            end else if (md_op == 3'd4) begin
              hi <= rs_val;
            end else if (md_op == 3'd5) begin
              lo <= rs_val;
            end
          end
        end
        RUN: begin
          // Requests arriving here are dropped; the hazard unit is expected to stall them.
          if (count == CW'(1)) begin
            if (commit_n) begin
              hi <= hi_n;
              lo <= lo_n;
            end
            count <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            count <= count - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected HI/LO and busy length, a monitor checks them on commit.
`timescale 1ns/1ps
module tb_md_unit;

  typedef longint unsigned u64_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          n;
    logic [2:0]  op;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          free_cyc = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: plain 64-bit arithmetic on the architectural HI/LO.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int t);
    exp_t   e;
    int     n;
    longint sa;
    longint sb;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    case (op)
      3'd0: begin {m_hi, m_lo} = 64'(sa * sb); n = 5; end
      3'd1: begin {m_hi, m_lo} = u64_t'(a) * u64_t'(b); n = 5; end
      3'd2: begin
        n = 10;
        if (b != 32'd0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
      end
      3'd3: begin
        n = 10;
        if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; end
      end
      3'd4: begin m_hi = a; n = 0; end
      3'd5: begin m_lo = a; n = 0; end
      default: return;
    endcase
    e.due = t + n + 1;
    e.n   = n;
    e.op  = op;
    e.hi  = m_hi;
    e.lo  = m_lo;
    q.push_back(e);
    free_cyc = t + n + 1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (cyc < free_cyc && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("issue_wait_timeout", 32'(guard), 32'd0);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    $display("issue op=%0d rs=%h rt=%h cycle=%0d", op, a, b, cyc);
    model(op, a, b, cyc);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Start while a multi-cycle op is running: must be dropped, so the model is untouched.
  task automatic issue_ignored(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    if (cyc < free_cyc) begin
      start = 1'b1; md_op = op; rs_val = a; rt_val = b;
      $display("issue (while running) op=%0d rs=%h rt=%h cycle=%0d", op, a, b, cyc);
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  int   run = 0;
  int   last_run = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      run = 0; last_run = 0; prev_busy = 1'b0;
    end else begin
      if (busy) run++;
      else if (run != 0) begin last_run = run; run = 0; end
      if (busy && !prev_busy) begin
        checks++;
        if (q.size() == 0 || q[0].n == 0) begin
          errors++;
          $display("FAIL busy_rise: busy=1 expected 0 (no multi-cycle op pending, cycle %0d)", cyc);
        end
      end
      prev_busy = busy;
      if (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        $display("commit op=%0d cycle=%0d hi=%h lo=%h exp_hi=%h exp_lo=%h busy_len=%0d", e.op, cyc, hi, lo, e.hi, e.lo, last_run);
        check($sformatf("op%0d_hi", e.op), hi, e.hi);
        check($sformatf("op%0d_lo", e.op), lo, e.lo);
        check($sformatf("op%0d_busy_after", e.op), 32'(busy), 32'd0);
        if (e.n > 0) check($sformatf("op%0d_busy_len", e.op), 32'(last_run), 32'(e.n));
        last_run = 0;
      end
    end
  end

  initial begin
    int          guard;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    rst_n = 1'b1;
    free_cyc = cyc;

    // Async reset in the middle of a mult.
    issue(3'd4, 32'hAAAA_5555, 32'd0);
    issue(3'd5, 32'h5555_AAAA, 32'd0);
    issue(3'd0, 32'd5, 32'd7);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_busy", 32'(busy), 32'd0);
    check("async_reset_hi", hi, 32'd0);
    check("async_reset_lo", lo, 32'd0);
    q.delete();
    m_hi = 32'd0; m_lo = 32'd0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    free_cyc = cyc;
    repeat (10) @(posedge clk);
    #1;
    check("post_reset_hi", hi, 32'd0);
    check("post_reset_lo", lo, 32'd0);

    // Directed cases; consecutive issues land back-to-back.
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    issue(3'd3, 32'd7, 32'd2);
    issue(3'd4, 32'h11, 32'd0);
    issue(3'd5, 32'h22, 32'd0);
    issue(3'd2, 32'h1234, 32'd0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd4, 32'hDEAD_BEEF, 32'd0);
    issue(3'd0, 32'h1000, 32'h10);
    issue_ignored(3'd5, 32'hCAFE_F00D, 32'd0);
    issue(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd6, 32'h1357_9BDF, 32'h2468_ACE0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9)) * (($urandom_range(0, 1) != 0) ? 32'd1 : 32'hFFFF_FFFF);
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
      issue(op, a, b);
      if (!op[2] && $urandom_range(0, 3) == 0)
        issue_ignored(3'($urandom_range(0, 7)), $urandom, $urandom);
    end

    guard = 0;
    while (q.size() > 0 && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) check("drain_timeout", 32'(q.size()), 32'd0);
    @(negedge clk);
    check("final_hi", hi, m_hi);
    check("final_lo", lo, m_lo);
    check("final_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
